instr_prefetch_buffer: RTL and testbench

Instruction fetch front end between a wait-stated instruction memory and the IF/ID register of the 5-stage RISC-V pipeline. It keeps its own fetch PC and issues sequential word requests over a req/ready handshake. Fetched words, with their PC and PC+4, are queued in a small FIFO. The queue drains into decode under the core's stall signal and is flushed on a taken branch/jump redirect from EX.

---
 rtl/rv_fetch_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/instr_prefetch_buffer.sv | 183 ++++++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
//   NOP_INSTR     : canonical RISC-V NOP (addi x0, x0, 0) shown to decode on a bubble
//   fetch_state_t : fetch FSM states
//   fetch_entry_t : one queued fetch result {instruction, its PC, PC+4}
//   next_word_pc  : sequential word increment, wraps modulo 2^32
package rv_fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } fetch_entry_t;

    function automatic logic [31:0] next_word_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head read.
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   push, wdata       : write request and data (ignored when full)
//   pop               : remove head entry (ignored when empty)
//   flush             : empty the queue; overrides push and pop
//   rdata             : head entry (stale contents when empty)
//   count, full, empty: occupancy status
module sync_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests against occupancy so the pointers can never overrun.
    always_comb begin
        do_push_s = push && !full && !flush;
        do_pop_s  = pop && !empty && !flush;
    end

    // Pointer and occupancy registers; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Status and head read.
    always_comb begin
        rdata = mem_r[rd_ptr_r];
        count = count_r;
        full  = (count_r == (AW+1)'(DEPTH));
        empty = (count_r == (AW+1)'(0));
    end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer between a wait-stated instruction memory and IF/ID.
// Keeps its own fetch PC, issues sequential word requests (held stable until
// mem_ready), queues {instr, pc, pc+4} and drains into decode under instr_ready.
// A redirect flushes the queue; an in-flight request is completed and its word
// dropped (DISCARD) before fetching resumes at the target.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   redirect, redirect_pc      : taken branch/jump and its target (low bits ignored)
//   instr_ready                : decode accepts the head this cycle
//   instr_valid/out/pc/pc4     : head entry, NOP/0/0 when empty
//   mem_req, mem_addr          : registered fetch request
//   mem_ready, mem_rdata       : memory completion and returned word
module instr_prefetch_buffer
    import rv_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc4,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_r, state_n;
    logic [31:0]   fetch_pc_r, fetch_pc_n;
    logic [31:0]   target_r, target_n;
    logic          mem_req_r, mem_req_n;
    logic [31:0]   mem_addr_r, mem_addr_n;

    logic [31:0]   redirect_tgt_s;
    logic          accept_s;
    logic          hold_req_s;
    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] fifo_count_s;
    logic [CW-1:0] count_n_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    fetch_entry_t  wentry_s;
    fetch_entry_t  head_s;

    // Handshake decode; a redirect cancels any push or pop in its cycle.
    always_comb begin
        redirect_tgt_s = redirect_pc & 32'hFFFF_FFFC;
        accept_s       = mem_req_r && mem_ready;
        hold_req_s     = mem_req_r && !mem_ready;
        pop_s          = !fifo_empty_s && instr_ready && !redirect;
        push_s         = (state_r == FETCH) && accept_s && !redirect && !fifo_full_s;
        wentry_s.instr = mem_rdata;
        wentry_s.pc    = fetch_pc_r;
        wentry_s.pc4   = next_word_pc(fetch_pc_r);
    end

    // Occupancy after this edge, used to decide whether a new request may start.
    always_comb begin
        count_n_s = fifo_count_s;
        if (redirect) begin
            count_n_s = CW'(0);
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_n_s = fifo_count_s + CW'(1);
                2'b01:   count_n_s = fifo_count_s - CW'(1);
                default: count_n_s = fifo_count_s;
            endcase
        end
    end

    // Fetch FSM next state, fetch PC and saved redirect target.
    always_comb begin
        state_n    = state_r;
        fetch_pc_n = fetch_pc_r;
        target_n   = target_r;
        case (state_r)
            FETCH: begin
                if (redirect) begin
                    target_n = redirect_tgt_s;
                    if (hold_req_s) begin
                        state_n = DISCARD;
                    end else begin
                        fetch_pc_n = redirect_tgt_s;
                    end
                end else if (accept_s) begin
                    fetch_pc_n = next_word_pc(fetch_pc_r);
                end else begin
                    fetch_pc_n = fetch_pc_r;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    target_n = redirect_tgt_s;
                end else begin
                    target_n = target_r;
                end
                // The dropped response closes the request; resume at the latest target.
                if (accept_s) begin
                    state_n    = FETCH;
                    fetch_pc_n = redirect ? redirect_tgt_s : target_r;
                end else begin
                    state_n = DISCARD;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    // Request generation: an open request is held; otherwise start one only if space remains.
    always_comb begin
        mem_req_n  = 1'b0;
        mem_addr_n = mem_addr_r;
        if (hold_req_s) begin
            mem_req_n  = 1'b1;
            mem_addr_n = mem_addr_r;
        end else begin
            mem_req_n  = (state_n == FETCH) && (count_n_s < CW'(DEPTH));
            mem_addr_n = fetch_pc_n;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= FETCH;
            fetch_pc_r <= RESET_PC;
            target_r   <= RESET_PC;
            mem_req_r  <= 1'b0;
            mem_addr_r <= RESET_PC;
        end else begin
            state_r    <= state_n;
            fetch_pc_r <= fetch_pc_n;
            target_r   <= target_n;
            mem_req_r  <= mem_req_n;
            mem_addr_r <= mem_addr_n;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect),
        .wdata (wentry_s),
        .rdata (head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Output gating: decode sees a NOP bubble with zero PCs when the queue is empty.
    always_comb begin
        mem_req  = mem_req_r;
        mem_addr = mem_addr_r;
        if (!fifo_empty_s) begin
            instr_valid = 1'b1;
            instr_out   = head_s.instr;
            instr_pc    = head_s.pc;
            instr_pc4   = head_s.pc4;
        end else begin
            instr_valid = 1'b0;
            instr_out   = NOP_INSTR;
            instr_pc    = 32'h0000_0000;
            instr_pc4   = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer (DEPTH=4, RESET_PC=0x100).
// The memory model returns mem_addr ^ 0x5A5A_0000 as the instruction word.
module tb_instr_prefetch_buffer;

    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem_addr ^ KEY;

    instr_prefetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_pc4   (instr_pc4),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_pc"},    instr_pc,  pc);
        chk({tag, "_pc4"},   instr_pc4, pc + 32'd4);
        chk({tag, "_instr"}, instr_out, pc ^ KEY);
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_nop"},   instr_out, 32'h0000_0013);
        chk({tag, "_pc"},    instr_pc,  32'h0000_0000);
        chk({tag, "_pc4"},   instr_pc4, 32'h0000_0000);
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;
        instr_ready = 1'b1;
        mem_ready   = 1'b1;
        tick();
        tick();

        // Reset state
        chk_bubble("rst");
        chk("rst_req",  {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0000_0100);

        // Sequential zero-wait fetch
        reset = 1'b0;
        tick();
        chk_bubble("c1");
        chk("c1_req",  {31'd0, mem_req}, 32'd1);
        chk("c1_addr", mem_addr, 32'h0000_0100);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_head("seq", 32'h0000_0100 + 32'(4 * i));
            chk("seq_addr", mem_addr, 32'h0000_0104 + 32'(4 * i));
        end

        // Backpressure: hold decode for 10 cycles, queue fills and requests stop
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_head("hold", 32'h0000_010C);
        end
        chk("full_req", {31'd0, mem_req}, 32'd0);
        instr_ready = 1'b1;
        tick();
        chk_head("rel1", 32'h0000_0110);
        chk("rel_req",  {31'd0, mem_req}, 32'd1);
        chk("rel_addr", mem_addr, 32'h0000_011C);
        tick();
        chk_head("rel2", 32'h0000_0114);
        tick();
        chk_head("rel3", 32'h0000_0118);
        tick();
        chk_head("rel4", 32'h0000_011C);

        // Redirect with zero-wait memory; low target bits are ignored
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0403;
        tick();
        redirect = 1'b0;
        chk_bubble("rd1");
        chk("rd1_req",  {31'd0, mem_req}, 32'd1);
        chk("rd1_addr", mem_addr, 32'h0000_0400);
        tick();
        chk_head("rd2", 32'h0000_0400);

        // Build two entries, then redirect together with a push and a pop
        instr_ready = 1'b0;
        tick();
        chk_head("two", 32'h0000_0400);
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0800;
        tick();
        redirect = 1'b0;
        chk_bubble("rdp");
        chk("rdp_addr", mem_addr, 32'h0000_0800);
        tick();
        chk_head("rdp2", 32'h0000_0800);

        // Address wrap at the top of memory
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        chk("wrap_addr", mem_addr, 32'hFFFF_FFF8);
        tick();
        chk_head("wrap0", 32'hFFFF_FFF8);
        chk("wrap0_addr", mem_addr, 32'hFFFF_FFFC);
        tick();
        chk_head("wrap1", 32'hFFFF_FFFC);
        chk("wrap1_pc4", instr_pc4, 32'h0000_0000);
        tick();
        chk_head("wrap2", 32'h0000_0000);

        // Wait-stated memory, redirect while a request is open
        mem_ready = 1'b0;
        tick();
        chk_bubble("ws0");
        chk("ws0_addr", mem_addr, 32'h0000_0004);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2003;
        tick();
        redirect = 1'b0;
        chk_bubble("dis1");
        chk("dis1_req",  {31'd0, mem_req}, 32'd1);
        chk("dis1_addr", mem_addr, 32'h0000_0004);
        tick();
        chk("dis2_addr", mem_addr, 32'h0000_0004);
        mem_ready = 1'b1;
        tick();
        chk_bubble("dis3");
        chk("dis3_req",  {31'd0, mem_req}, 32'd1);
        chk("dis3_addr", mem_addr, 32'h0000_2000);
        mem_ready = 1'b0;
        tick();
        chk_bubble("tw1");
        chk("tw1_addr", mem_addr, 32'h0000_2000);
        tick();
        chk_bubble("tw2");
        mem_ready = 1'b1;
        tick();
        chk_head("tgt", 32'h0000_2000);

        // Reset with entries queued and a request open
        instr_ready = 1'b0;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        chk_head("pre_rst", 32'h0000_2000);
        chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        tick();
        chk_bubble("mrst");
        chk("mrst_req", {31'd0, mem_req}, 32'd0);
        reset       = 1'b0;
        mem_ready   = 1'b1;
        instr_ready = 1'b1;
        tick();
        chk("rst2_req",  {31'd0, mem_req}, 32'd1);
        chk("rst2_addr", mem_addr, 32'h0000_0100);
        tick();
        chk_head("rst2", 32'h0000_0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
